// File: rtl/spi_frame_rx.sv
// Serial frame receiver: CS/SCLK/DI link, LSB-first word assembly.
// Optional even-parity bit enabled by SPI_FRAME_RX_PARITY_EN.
module spi_frame_rx #(
  parameter int DATA_W      = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              DI,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              busy,
  output logic              parity_err
);

`ifdef SPI_FRAME_RX_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif
  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RX,
    DONE,
    WAIT_CS
  } state_t;

  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] di_q;
  logic [SYNC_STAGES-1:0] fill;
  logic                   cs_d;
  logic                   sclk_d;
  logic                   cs_ok;

  logic cs_s;
  logic sclk_s;
  logic di_s;
  logic sclk_rise;
  logic cs_rise;
  logic cs_fall;

  state_t             state;
  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-1:0] bit_in;

  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign di_s      = di_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  // Arming needs a real CS-high seen first, so a CS held low
  // through reset cannot look like a fresh falling edge.
  assign cs_fall   = ~cs_s & cs_d & cs_ok;
  assign bit_in    = FRAME_W'(di_s) << cnt;

  // Input synchronizers, edge history and the CS-high qualifier
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q   <= '1;
      sclk_q <= '0;
      di_q   <= '0;
      fill   <= '0;
      cs_d   <= 1'b1;
      sclk_d <= 1'b0;
      cs_ok  <= 1'b0;
    end else begin
      cs_q   <= {cs_q[SYNC_STAGES-2:0], CS};
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], SCLK};
      di_q   <= {di_q[SYNC_STAGES-2:0], DI};
      fill   <= {fill[SYNC_STAGES-2:0], 1'b1};
      cs_d   <= cs_s;
      sclk_d <= sclk_s;
      cs_ok  <= cs_ok | (fill[SYNC_STAGES-1] & cs_s);
    end
  end

  // Frame state machine with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      cnt        <= '0;
      shreg      <= '0;
`ifdef SPI_FRAME_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef SPI_FRAME_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          busy  <= 1'b0;
          cnt   <= '0;
          shreg <= '0;
          if (cs_fall) begin
            busy <= 1'b1;
            if (sclk_rise) begin
              shreg <= FRAME_W'(di_s);
              cnt   <= CNT_W'(1);
              state <= RX;
            end else begin
              state <= ARMED;
            end
          end
        end
        ARMED: begin
          if (cs_rise) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (sclk_rise) begin
            shreg <= bit_in;
            cnt   <= cnt + CNT_W'(1);
            state <= RX;
          end
        end
        RX: begin
          if (cs_rise) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (sclk_rise) begin
            shreg <= shreg | bit_in;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end
        DONE: begin
          data_out   <= shreg[DATA_W-1:0];
          data_valid <= 1'b1;
`ifdef SPI_FRAME_RX_PARITY_EN
          parity_err <= ^shreg;
`endif
          if (cs_rise) begin
            state <= IDLE;
          end else begin
            state <= WAIT_CS;
            if (sclk_rise)
              frame_err <= 1'b1;
          end
        end
        WAIT_CS: begin
          if (cs_rise)
            state <= IDLE;
          else if (sclk_rise & ~cs_s)
            frame_err <= 1'b1;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SPI_FRAME_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// Scoreboard bench for spi_frame_rx.
// Define SPI_FRAME_RX_PARITY_EN to exercise the parity build.
module tb_spi_frame_rx;

  localparam int DW = 6;
  localparam int SS = 2;
`ifdef SPI_FRAME_RX_PARITY_EN
  localparam int FL = DW + 1;
`else
  localparam int FL = DW;
`endif

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          SCLK = 1'b0;
  logic          CS   = 1'b0;
  logic          DI   = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          busy;
  logic          parity_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_rise   = 0;
  int valid_cyc   = 0;

  typedef struct {
    logic          kind;
    logic [DW-1:0] data;
    logic          perr;
  } exp_t;

  exp_t q[$];
  exp_t me;

  spi_frame_rx #(
    .DATA_W(DW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .SCLK(SCLK),
    .CS(CS),
    .DI(DI),
    .data_out(data_out),
    .data_valid(data_valid),
    .frame_err(frame_err),
    .busy(busy),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] mk(input logic [DW-1:0] d,
                                     input logic p);
    logic [16:0] f;
    f     = 17'(d);
    f[DW] = p;
    return f;
  endfunction

  task automatic expect_word(input logic [DW-1:0] d, input logic pe);
    q.push_back('{1'b0, d, pe});
  endtask

  task automatic expect_err();
    q.push_back('{1'b1, '0, 1'b0});
  endtask

  task automatic send_bits(input logic [16:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      DI = b[i];
      tick(8);
      SCLK = 1'b1;
      last_rise = cyc;
      tick(8);
      SCLK = 1'b0;
    end
  endtask

  // Monitor: every output pulse must match the head of the queue
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        valid_cyc = cyc;
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_valid: got data %0h", data_out);
        end else begin
          me = q.pop_front();
          if (me.kind !== 1'b0 || data_out !== me.data ||
              parity_err !== me.perr) begin
            miscompares++;
            $display("FAIL valid: got kind 0 data %0h perr %0b want kind %0b data %0h perr %0b",
                     data_out, parity_err, me.kind, me.data, me.perr);
          end
        end
      end
      if (frame_err) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_frame_err: got 1 want 0");
        end else begin
          me = q.pop_front();
          if (me.kind !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_err: got error want valid data %0h",
                     me.data);
          end
        end
      end
      if (parity_err && !data_valid) begin
        vectors++;
        miscompares++;
        $display("FAIL stray_parity_err: got 1 want 0");
      end
    end
  end

  initial begin
    // reset held with CS low and SCLK toggling
    rst = 1'b1;
    CS  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      SCLK = ~SCLK;
    end
    rst = 1'b0;
    tick(1);
    check("rst_data_out", 16'(data_out), 16'h0);
    check("rst_data_valid", 16'(data_valid), 16'h0);
    check("rst_frame_err", 16'(frame_err), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_parity_err", 16'(parity_err), 16'h0);
    DI = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(8);
      SCLK = ~SCLK;
    end
    tick(8);
    check("no_arm_after_rst_busy", 16'(busy), 16'h0);

    // nominal frame 0x0D with latency check
    CS = 1'b1;
    tick(8);
    CS = 1'b0;
    tick(8);
    check("armed_busy", 16'(busy), 16'h1);
    expect_word(6'h0D, 1'b0);
    send_bits(mk(6'h0D, 1'b1), FL);
    check("latency", 16'(valid_cyc - last_rise), 16'(SS + 2));
    check("wait_cs_busy", 16'(busy), 16'h0);
    CS = 1'b1;
    tick(8);

    // abort after 3 bits, then a clean 0x2A frame
    CS = 1'b0;
    tick(8);
    expect_err();
    send_bits(mk(6'h3F, 1'b0), 3);
    CS = 1'b1;
    tick(8);
    check("abort_keeps_data", 16'(data_out), 16'h0D);
    check("abort_busy", 16'(busy), 16'h0);
    CS = 1'b0;
    tick(8);
    expect_word(6'h2A, 1'b0);
    send_bits(mk(6'h2A, 1'b1), FL);
    CS = 1'b1;
    tick(8);
    check("after_abort_data", 16'(data_out), 16'h2A);

    // overrun: two extra rises after a complete 0x15 frame
    CS = 1'b0;
    tick(8);
    expect_word(6'h15, 1'b0);
    expect_err();
    expect_err();
    send_bits(mk(6'h15, 1'b1) | (17'b11 << FL), FL + 2);
    CS = 1'b1;
    tick(8);
    check("overrun_data", 16'(data_out), 16'h15);

    // empty frame produces nothing
    CS = 1'b0;
    tick(8);
    check("empty_busy_hi", 16'(busy), 16'h1);
    CS = 1'b1;
    tick(8);
    check("empty_busy_lo", 16'(busy), 16'h0);

    // CS rise coincident with the 4th SCLK rise
    CS = 1'b0;
    tick(8);
    expect_err();
    send_bits(mk(6'h3F, 1'b0), 3);
    DI = 1'b1;
    tick(8);
    SCLK = 1'b1;
    CS   = 1'b1;
    tick(8);
    SCLK = 1'b0;
    tick(8);
    check("simul_keeps_data", 16'(data_out), 16'h15);

    // boundary words: all ones, MSB only
    CS = 1'b0;
    tick(8);
    expect_word(6'h3F, 1'b0);
    send_bits(mk(6'h3F, 1'b0), FL);
    CS = 1'b1;
    tick(8);
    CS = 1'b0;
    tick(8);
    expect_word(6'h20, 1'b0);
    send_bits(mk(6'h20, 1'b1), FL);
    CS = 1'b1;
    tick(8);

`ifdef SPI_FRAME_RX_PARITY_EN
    // parity good then parity bad on the same data
    CS = 1'b0;
    tick(8);
    expect_word(6'h07, 1'b0);
    send_bits(mk(6'h07, 1'b1), FL);
    CS = 1'b1;
    tick(8);
    CS = 1'b0;
    tick(8);
    expect_word(6'h07, 1'b1);
    send_bits(mk(6'h07, 1'b0), FL);
    CS = 1'b1;
    tick(8);
    check("parity_data", 16'(data_out), 16'h07);
`endif

    tick(20);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
